// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: datapath widths, MEM-stage FSM states and the
// word-alignment helper used by the memory stage.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Only the two low address bits decide word alignment.
    function automatic logic is_word_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register. A bubble clears the control bits and holds the
// data fields; load captures a new entry, with read data captured separately.
module mem_wb
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_bubble,
    input  logic                  i_rdata_load,
    input  logic                  i_regwrite,
    input  logic                  i_memtoreg,
    input  logic [XLEN-1:0]       i_mem_rdata,
    input  logic [XLEN-1:0]       i_alu_result,
    input  logic [REG_ADDR_W-1:0] i_rd,
    output logic                  o_regwrite,
    output logic                  o_memtoreg,
    output logic [XLEN-1:0]       o_mem_rdata,
    output logic [XLEN-1:0]       o_alu_result,
    output logic [REG_ADDR_W-1:0] o_rd
);

    logic                  r_regwrite;
    logic                  r_memtoreg;
    logic [XLEN-1:0]       r_mem_rdata;
    logic [XLEN-1:0]       r_alu_result;
    logic [REG_ADDR_W-1:0] r_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_mem_rdata  <= '0;
            r_alu_result <= '0;
            r_rd         <= '0;
        end else if (i_bubble) begin
            r_regwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
        end else if (i_load) begin
            r_regwrite   <= i_regwrite;
            r_memtoreg   <= i_memtoreg;
            r_alu_result <= i_alu_result;
            r_rd         <= i_rd;
            if (i_rdata_load) begin
                r_mem_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_regwrite   = r_regwrite;
    assign o_memtoreg   = r_memtoreg;
    assign o_mem_rdata  = r_mem_rdata;
    assign o_alu_result = r_alu_result;
    assign o_rd         = r_rd;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues data-memory requests, stalls the pipeline while a
// request is outstanding, flags illegal/misaligned accesses and feeds MEM/WB.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite_in,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic                  MemToReg_in,
    input  logic [XLEN-1:0]       alu_result_in,
    input  logic [XLEN-1:0]       rs2_data_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  dmem_valid,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  stall,
    output logic                  fault,
    output logic                  RegWrite,
    output logic                  MemToReg,
    output logic [XLEN-1:0]       mem_rdata,
    output logic [XLEN-1:0]       alu_result,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       stall_count
);

    mem_state_t r_state;
    mem_state_t w_next_state;

    logic                  r_lat_we;
    logic                  r_lat_re;
    logic                  r_lat_regwrite;
    logic                  r_lat_memtoreg;
    logic [XLEN-1:0]       r_lat_addr;
    logic [XLEN-1:0]       r_lat_wdata;
    logic [REG_ADDR_W-1:0] r_lat_rd;

    logic            r_fault;
    logic [XLEN-1:0] r_stall_count;

    logic w_mem_op;
    logic w_illegal;
    logic w_misaligned;

    logic                  w_dmem_valid;
    logic                  w_dmem_we;
    logic [XLEN-1:0]       w_dmem_addr;
    logic [XLEN-1:0]       w_dmem_wdata;
    logic                  w_stall;
    logic                  w_latch;
    logic                  w_fault_set;
    logic                  w_wb_load;
    logic                  w_wb_bubble;
    logic                  w_wb_rdata_load;
    logic                  w_wb_regwrite;
    logic                  w_wb_memtoreg;
    logic [XLEN-1:0]       w_wb_alu_result;
    logic [REG_ADDR_W-1:0] w_wb_rd;

    assign w_mem_op     = MemRead_in ^ MemWrite_in;
    assign w_illegal    = MemRead_in & MemWrite_in;
    assign w_misaligned = (ALIGN_CHECK != 0) && w_mem_op
                          && is_word_misaligned(alu_result_in[1:0]);

    // Combinational outputs are gated by reset so nothing is requested or
    // stalled in the reset cycle, including when reset abandons a WAIT.
    always_comb begin
        w_next_state    = r_state;
        w_dmem_valid    = 1'b0;
        w_dmem_we       = 1'b0;
        w_dmem_addr     = alu_result_in;
        w_dmem_wdata    = rs2_data_in;
        w_stall         = 1'b0;
        w_latch         = 1'b0;
        w_fault_set     = 1'b0;
        w_wb_load       = 1'b0;
        w_wb_bubble     = 1'b0;
        w_wb_rdata_load = 1'b0;
        w_wb_regwrite   = RegWrite_in;
        w_wb_memtoreg   = MemToReg_in;
        w_wb_alu_result = alu_result_in;
        w_wb_rd         = rd_in;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (w_illegal || w_misaligned) begin
                        w_fault_set = 1'b1;
                        w_wb_bubble = 1'b1;
                    end else if (w_mem_op) begin
                        w_dmem_valid = 1'b1;
                        w_dmem_we    = MemWrite_in;
                        if (dmem_ready) begin
                            w_wb_load       = 1'b1;
                            w_wb_rdata_load = MemRead_in;
                        end else begin
                            w_stall      = 1'b1;
                            w_latch      = 1'b1;
                            w_wb_bubble  = 1'b1;
                            w_next_state = WAIT;
                        end
                    end else begin
                        w_wb_load = 1'b1;
                    end
                end
                WAIT: begin
                    w_dmem_valid    = 1'b1;
                    w_dmem_we       = r_lat_we;
                    w_dmem_addr     = r_lat_addr;
                    w_dmem_wdata    = r_lat_wdata;
                    w_wb_regwrite   = r_lat_regwrite;
                    w_wb_memtoreg   = r_lat_memtoreg;
                    w_wb_alu_result = r_lat_addr;
                    w_wb_rd         = r_lat_rd;
                    if (dmem_ready) begin
                        w_wb_load       = 1'b1;
                        w_wb_rdata_load = r_lat_re;
                        w_next_state    = IDLE;
                    end else begin
                        w_stall     = 1'b1;
                        w_wb_bubble = 1'b1;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lat_we       <= 1'b0;
            r_lat_re       <= 1'b0;
            r_lat_regwrite <= 1'b0;
            r_lat_memtoreg <= 1'b0;
            r_lat_addr     <= '0;
            r_lat_wdata    <= '0;
            r_lat_rd       <= '0;
        end else if (w_latch) begin
            r_lat_we       <= MemWrite_in;
            r_lat_re       <= MemRead_in;
            r_lat_regwrite <= RegWrite_in;
            r_lat_memtoreg <= MemToReg_in;
            r_lat_addr     <= alu_result_in;
            r_lat_wdata    <= rs2_data_in;
            r_lat_rd       <= rd_in;
        end
    end

    // Fault is presented alongside the bubble it creates in MEM/WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault       <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_fault <= w_fault_set;
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    mem_wb u_mem_wb (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_wb_load),
        .i_bubble     (w_wb_bubble),
        .i_rdata_load (w_wb_rdata_load),
        .i_regwrite   (w_wb_regwrite),
        .i_memtoreg   (w_wb_memtoreg),
        .i_mem_rdata  (dmem_rdata),
        .i_alu_result (w_wb_alu_result),
        .i_rd         (w_wb_rd),
        .o_regwrite   (RegWrite),
        .o_memtoreg   (MemToReg),
        .o_mem_rdata  (mem_rdata),
        .o_alu_result (alu_result),
        .o_rd         (rd)
    );

    assign dmem_valid  = w_dmem_valid;
    assign dmem_we     = w_dmem_we;
    assign dmem_addr   = w_dmem_addr;
    assign dmem_wdata  = w_dmem_wdata;
    assign stall       = w_stall;
    assign fault       = r_fault;
    assign stall_count = r_stall_count;

endmodule
